// File: rtl/button_pkg.sv
// ---------------------------------------------------------------------------
// button_pkg
// Shared definitions for the button event generator:
//   - btn_state_t : per-channel press FSM states (IDLE, PRESSED, HELD)
//   - BTN_SW / BTN_LEFT / BTN_RIGHT : channel index of each board button
//   - cnt_width() : counter width for a terminal count, at least 1 bit
// ---------------------------------------------------------------------------
package button_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      HELD    = 2'd2
   } btn_state_t;

   localparam int BTN_SW    = 0;
   localparam int BTN_LEFT  = 1;
   localparam int BTN_RIGHT = 2;

   // Width of a counter that must count from 0 up to n-1.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/button_channel.sv
// ---------------------------------------------------------------------------
// button_channel
// One button: 2-FF synchronizer, debounce filter and press/long/repeat FSM.
// Auto-repeat while held exists only when BUTTON_EVENT_REPEAT_EN is defined;
// otherwise the hold counter freezes in HELD and o_repeat stays 0.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   i_btn       : raw asynchronous button pin (active-high)
//   o_level     : debounced level
//   o_press     : one-cycle strobe, level went 0->1
//   o_release   : one-cycle strobe, level went 1->0 after a press
//   o_long      : one-cycle strobe, press lasted LONG_CYCLES
//   o_repeat    : one-cycle strobe every REPEAT_CYCLES after the long press
// ---------------------------------------------------------------------------
module button_channel
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 2000000,
   parameter int LONG_CYCLES     = 100000000,
   parameter int REPEAT_CYCLES   = 20000000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_long,
   output logic o_repeat
);

   localparam int DEB_W   = cnt_width(DEBOUNCE_CYCLES);
   localparam int HOLD_MX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
   localparam int HOLD_W  = cnt_width(HOLD_MX);

   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
`ifdef BUTTON_EVENT_REPEAT_EN
   localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);
`endif

   logic              r_sync1;
   logic              r_sync2;
   logic [DEB_W-1:0]  r_deb_cnt;
   logic              r_level;
   btn_state_t        r_state;
   logic [HOLD_W-1:0] r_hold;
   logic              r_press;
   logic              r_release;
   logic              r_long;
   logic              r_repeat;

   logic w_differ;
   logic w_toggle;
   logic w_rise;
   logic w_fall;

   // The level flips on the same edge the FSM sees w_rise/w_fall, so the
   // strobes appear in the very cycle the new level is first visible.
   assign w_differ = (r_sync2 != r_level);
   assign w_toggle = w_differ && (r_deb_cnt == DEB_LAST);
   assign w_rise   = w_toggle && !r_level;
   assign w_fall   = w_toggle &&  r_level;

   // Synchronizer and debounce filter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_deb_cnt <= '0;
         r_level   <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         if (!w_differ) begin
            r_deb_cnt <= '0;
         end else if (w_toggle) begin
            r_deb_cnt <= '0;
            r_level   <= ~r_level;
         end else begin
            r_deb_cnt <= r_deb_cnt + DEB_W'(1);
         end
      end
   end

   // Press FSM with registered strobes; release always wins over a
   // coinciding long/repeat threshold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_hold    <= '0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_long    <= 1'b0;
         r_repeat  <= 1'b0;
      end else begin
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_long    <= 1'b0;
         r_repeat  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_rise) begin
                  r_press <= 1'b1;
                  r_hold  <= '0;
                  r_state <= PRESSED;
               end
            end
            PRESSED: begin
               if (w_fall) begin
                  r_release <= 1'b1;
                  r_state   <= IDLE;
               end else if (r_hold == LONG_LAST) begin
                  r_long  <= 1'b1;
                  r_hold  <= '0;
                  r_state <= HELD;
               end else begin
                  r_hold <= r_hold + HOLD_W'(1);
               end
            end
            HELD: begin
               if (w_fall) begin
                  r_release <= 1'b1;
                  r_state   <= IDLE;
               end
`ifdef BUTTON_EVENT_REPEAT_EN
               else if (r_hold == REP_LAST) begin
                  r_repeat <= 1'b1;
                  r_hold   <= '0;
               end else begin
                  r_hold <= r_hold + HOLD_W'(1);
               end
`endif
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_level   = r_level;
   assign o_press   = r_press;
   assign o_release = r_release;
   assign o_long    = r_long;
   assign o_repeat  = r_repeat;

endmodule

// File: rtl/button_event_gen.sv
// ---------------------------------------------------------------------------
// button_event_gen
// Debounces NUM_BTN raw buttons and produces press / release / long-press /
// auto-repeat strobes per button. Channels are fully independent.
// Build option: define BUTTON_EVENT_REPEAT_EN to enable auto-repeat;
// without it repeat_pulse is constant 0 (ports unchanged).
// Ports:
//   clk           : system clock
//   rst           : asynchronous active-high reset
//   btn_in        : raw button pins, active-high (bit 0 sw, 1 left, 2 right)
//   btn_level     : debounced levels
//   press_pulse   : one-cycle strobe per button on debounced 0->1
//   release_pulse : one-cycle strobe per button on debounced 1->0
//   long_pulse    : one-cycle strobe when a press reaches LONG_CYCLES
//   repeat_pulse  : one-cycle strobe every REPEAT_CYCLES after a long press
// ---------------------------------------------------------------------------
module button_event_gen
   import button_pkg::*;
#(
   parameter int NUM_BTN         = 3,
   parameter int DEBOUNCE_CYCLES = 2000000,
   parameter int LONG_CYCLES     = 100000000,
   parameter int REPEAT_CYCLES   = 20000000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn_in,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] press_pulse,
   output logic [NUM_BTN-1:0] release_pulse,
   output logic [NUM_BTN-1:0] long_pulse,
   output logic [NUM_BTN-1:0] repeat_pulse
);

   generate
      for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
         button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
         ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .i_btn     (btn_in[gi]),
            .o_level   (btn_level[gi]),
            .o_press   (press_pulse[gi]),
            .o_release (release_pulse[gi]),
            .o_long    (long_pulse[gi]),
            .o_repeat  (repeat_pulse[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_button_event_gen.sv
// ---------------------------------------------------------------------------
// tb_button_event_gen
// Directed scenarios followed by random button activity. A reference model
// states the behaviour directly: the level flips once the input, seen two
// cycles late, has disagreed with it for DEBOUNCE_CYCLES samples in a row;
// events are derived from the elapsed time since the press.
// ---------------------------------------------------------------------------
module tb_button_event_gen;

   localparam int N = 3;
   localparam int D = 4;
   localparam int L = 20;
   localparam int R = 5;
`ifdef BUTTON_EVENT_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] btn_in = '0;
   logic [N-1:0] btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse;

   always #5 clk = ~clk;

   button_event_gen #(
      .NUM_BTN         (N),
      .DEBOUNCE_CYCLES (D),
      .LONG_CYCLES     (L),
      .REPEAT_CYCLES   (R)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .btn_in        (btn_in),
      .btn_level     (btn_level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_pulse    (long_pulse),
      .repeat_pulse  (repeat_pulse)
   );

   int n_pass   = 0;
   int n_checks = 0;
   int cyc      = 0;

   // reference model state
   logic [N-1:0] hist [0:D];   // hist[0] = input seen at the previous edge
   logic [N-1:0] m_level, m_press, m_release, m_long, m_repeat;
   int           p_edge [N];

   task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs == exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic model_clear();
      for (int j = 0; j <= D; j++) hist[j] = '0;
      m_level   = '0;
      m_press   = '0;
      m_release = '0;
      m_long    = '0;
      m_repeat  = '0;
   endtask

   task automatic model_step();
      logic [N-1:0] nl;
      bit           all_diff;
      int           e;
      if (rst) begin
         model_clear();
      end else begin
         nl        = m_level;
         m_press   = '0;
         m_release = '0;
         m_long    = '0;
         m_repeat  = '0;
         for (int c = 0; c < N; c++) begin
            all_diff = 1'b1;
            for (int j = 1; j <= D; j++)
               if (hist[j][c] == m_level[c]) all_diff = 1'b0;
            if (all_diff) nl[c] = ~m_level[c];
            if (!m_level[c] && nl[c]) begin
               m_press[c] = 1'b1;
               p_edge[c]  = cyc;
            end else if (m_level[c] && !nl[c]) begin
               m_release[c] = 1'b1;
            end else if (m_level[c] && nl[c]) begin
               e = cyc - p_edge[c];
               if (e == L) m_long[c] = 1'b1;
               else if (REP && e > L && ((e - L) % R) == 0) m_repeat[c] = 1'b1;
            end
         end
         m_level = nl;
         for (int j = D; j >= 1; j--) hist[j] = hist[j-1];
         hist[0] = btn_in;
      end
   endtask

   task automatic check_all();
      check("level",   btn_level,     m_level);
      check("press",   press_pulse,   m_press);
      check("release", release_pulse, m_release);
      check("long",    long_pulse,    m_long);
      check("repeat",  repeat_pulse,  m_repeat);
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      model_step();
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   int t_lvl, t_p, t_p2, t_l, t_r, n_p, n_l, n_rep, n_any;
   int dur [N];

   initial begin
      model_clear();
      for (int c = 0; c < N; c++) begin
         p_edge[c] = 0;
         dur[c]    = 0;
      end

      // reset state
      idle(3);
      check("reset_level", btn_level, '0);
      rst = 1'b0;
      idle(3);

      // single press on sw: level and press strobe 6 cycles after the edge
      btn_in[0] = 1'b1;
      t_lvl = -1; t_p = -1; n_p = 0; n_any = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (btn_level[0] && t_lvl < 0) t_lvl = i;
         if (press_pulse[0]) begin n_p++; t_p = i; end
         n_any += $countones(press_pulse[2:1]) + $countones(release_pulse)
                + $countones(long_pulse) + $countones(repeat_pulse);
      end
      chk_int("sw_level_cycle", t_lvl, 6);
      chk_int("sw_press_cycle", t_p, 6);
      chk_int("sw_press_count", n_p, 1);
      chk_int("sw_other_strobes", n_any, 0);
      btn_in[0] = 1'b0;
      idle(12);

      // 3-cycle glitch on left: filtered out completely
      n_any = 0;
      for (int i = 1; i <= 14; i++) begin
         btn_in[1] = (i <= 3);
         tick();
         n_any += int'(btn_level[1]) + $countones(press_pulse | release_pulse | long_pulse | repeat_pulse);
      end
      chk_int("glitch_activity", n_any, 0);

      // right held 60 cycles: press, long, repeats, release (release wins at 66)
      t_p = -1; t_l = -1; t_r = -1; n_rep = 0;
      for (int i = 1; i <= 72; i++) begin
         btn_in[2] = (i <= 60);
         tick();
         if (press_pulse[2])   t_p = i;
         if (long_pulse[2])    t_l = i;
         if (release_pulse[2]) t_r = i;
         n_rep += int'(repeat_pulse[2]);
      end
      chk_int("hold_press_cycle", t_p, 6);
      chk_int("hold_long_after_press", t_l - t_p, L);
      chk_int("hold_repeat_count", n_rep, REP ? 7 : 0);
      chk_int("hold_release_after_fall", t_r - 60, 6);

      // release lands on the long threshold: release only
      t_r = -1; n_l = 0;
      for (int i = 1; i <= 40; i++) begin
         btn_in[2] = (i <= 20);
         tick();
         if (release_pulse[2]) t_r = i;
         n_l += int'(long_pulse[2]) + int'(repeat_pulse[2]);
      end
      chk_int("tie_release_cycle", t_r, 26);
      chk_int("tie_long_count", n_l, 0);

      // reset while HELD, button kept high: fresh press after reset
      btn_in[0] = 1'b1;
      idle(30);
      rst = 1'b1;
      model_clear();
      #1;
      check("rst_async_level", btn_level, '0);
      check("rst_async_strobes", press_pulse | release_pulse | long_pulse | repeat_pulse, '0);
      idle(3);
      rst = 1'b0;
      t_p = -1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (press_pulse[0] && t_p < 0) t_p = i;
      end
      chk_int("rst_repress_cycle", t_p, 6);
      btn_in[0] = 1'b0;
      idle(12);

      // simultaneous presses on sw and right
      btn_in = 3'b101;
      t_p = -1; t_p2 = -1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (press_pulse[0]) t_p  = i;
         if (press_pulse[2]) t_p2 = i;
      end
      chk_int("dual_press_sw", t_p, 6);
      chk_int("dual_press_right", t_p2, 6);
      btn_in = '0;
      idle(12);

      // random activity against the model
      for (int k = 0; k < 1500; k++) begin
         for (int c = 0; c < N; c++) begin
            if (dur[c] == 0) begin
               btn_in[c] = 1'($urandom_range(0, 1));
               dur[c]    = $urandom_range(1, 40);
            end else begin
               dur[c]--;
            end
         end
         if ($urandom_range(0, 299) == 0) begin
            rst = 1'b1;
            model_clear();
         end else begin
            rst = 1'b0;
         end
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/button_event_gen.md
BUTTON_EVENT_GEN -- requirements
Module: button_event_gen

Interface
REQ-001 SHALL have parameter NUM_BTN, default 3, number of independent button channels (bit 0 sw, 1 left, 2 right).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 2000000, consecutive stable cycles to accept a level change (20 ms at 100 MHz).
REQ-003 SHALL have parameter LONG_CYCLES, default 100000000, press duration to flag a long press (1 s).
REQ-004 SHALL have parameter REPEAT_CYCLES, default 20000000, auto-repeat period after a long press (200 ms).
REQ-005 SHALL have port clk, input, 1, system clock (100 MHz single-ended).
REQ-006 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have port btn_in, input, NUM_BTN, raw asynchronous button pins, active-high.
REQ-008 SHALL have port btn_level, output, NUM_BTN, debounced stable level.
REQ-009 SHALL have ports press_pulse, release_pulse, long_pulse, repeat_pulse, output, NUM_BTN each, one-cycle event strobes.

Function
REQ-010 SHALL pass each btn_in bit through a 2-FF synchronizer before any other logic.
REQ-011 SHALL, per channel, count consecutive cycles where synchronized input differs from btn_level, clear the count on any agreeing cycle, and toggle btn_level when the count reaches DEBOUNCE_CYCLES-1.
REQ-012 SHALL give latency from a clean btn_in edge to btn_level change of exactly DEBOUNCE_CYCLES+2 cycles.
REQ-013 SHALL run a per-channel FSM with states IDLE, PRESSED, HELD, plus a hold counter.
REQ-014 SHALL, in IDLE on btn_level 0->1, assert press_pulse in the same cycle btn_level first reads 1, clear hold counter, enter PRESSED.
REQ-015 SHALL, in PRESSED, increment hold counter; at LONG_CYCLES-1 assert long_pulse for one cycle, clear counter, enter HELD.
REQ-016 SHALL, in HELD with repeat compiled in, increment hold counter; at REPEAT_CYCLES-1 assert repeat_pulse, clear counter, remain HELD.
REQ-017 SHALL, in PRESSED or HELD on btn_level 1->0, assert release_pulse in the same cycle, enter IDLE.
REQ-018 SHALL give release priority when release and a long/repeat threshold coincide: release_pulse only, no long_pulse/repeat_pulse.
REQ-019 SHALL keep channels fully independent; simultaneous events on several channels all strobe in the same cycle.
REQ-020 SHALL never assert more than one strobe per channel per cycle.
REQ-021 SHALL size counters with $clog2 of the respective parameter; counters never wrap.

Reset
REQ-022 SHALL clear synchronizers, debounce counters, hold counters, btn_level and all strobes to 0 and FSMs to IDLE while rst is high, including mid-press.
REQ-023 SHALL, after rst deasserts with a button already held, treat it as a new press (press_pulse after DEBOUNCE_CYCLES+2 cycles).

Configuration
REQ-024 SHALL, with macro BUTTON_EVENT_REPEAT_EN defined, implement auto-repeat per REQ-016.
REQ-025 SHALL, without BUTTON_EVENT_REPEAT_EN, hold counter freeze in HELD, repeat_pulse tied to 0, ports unchanged.

Structure
REQ-026 SHALL place the FSM state enum (IDLE, PRESSED, HELD) and channel index constants (BTN_SW=0, BTN_LEFT=1, BTN_RIGHT=2) in shared package button_pkg.
REQ-027 SHALL implement one channel (synchronizer, debounce, FSM) as sub-module button_channel, instantiated NUM_BTN times by generate.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5, NUM_BTN=3)
REQ-028 SHALL test: btn_in[0] rises and holds 10 cycles -> btn_level[0] rises at cycle 6, press_pulse[0] one cycle at cycle 6, others 0.
REQ-029 SHALL test: btn_in[1] glitch high for 3 cycles -> no btn_level change, no strobes.
REQ-030 SHALL test: hold btn_in[2] 60 cycles -> press, long_pulse 20 cycles after press, repeat_pulse every 5 cycles afterwards, release_pulse 6 cycles after btn_in falls (none with macro undefined).
REQ-031 SHALL test: release timed so btn_level falls on the long threshold cycle -> release_pulse only.
REQ-032 SHALL test: rst pulsed mid-HELD with button still high -> all outputs 0 during rst, fresh press_pulse 6 cycles after rst falls.
REQ-033 SHALL test: btn_in[0] and btn_in[2] rise in the same cycle -> press_pulse[0] and press_pulse[2] in the same cycle.
